key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Mechanical-key debounce stage feeding the beeper-toggle logic.
- Synchronises a raw, bouncing, active-low push-button into sys_clk.
- Drives key_filter, a clean level that idles high and falls once per accepted press, plus one-cycle press/release strobes.
- A transition is accepted only after the input holds stable for CNT_MAX consecutive cycles.

Parameters:
CNT_MAX, 1_000_000, consecutive stable cycles required to accept a transition (20 ms at 50 MHz); legal range >= 2
CNT_W, $clog2(CNT_MAX), counter width (derived, not overridden)

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous, active-high reset
key_in  input  1  raw key, active-low (0 = pressed), asynchronous to sys_clk
key_filter  output  1  debounced level; 1 = released, 0 = pressed; falling edge = accepted press
key_press  output  1  one-cycle high strobe coincident with key_filter falling
key_release  output  1  one-cycle high strobe coincident with key_filter rising

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst is asynchronous and active-high.
- Reset values: key_filter=1, key_press=0, key_release=0, both synchroniser flops=1, cnt=0, state=S_RELEASED.
- Synchroniser: 2-FF chain on key_in; key_sync is the second-stage output. No logic reads key_in directly.
- FSM states and transitions, evaluated on each rising edge:
  - S_RELEASED: key_sync=0 -> S_PRESS_CHK, cnt<=0.
  - S_PRESS_CHK, key_sync=1: bounce; go to S_RELEASED, cnt<=0, no outputs change.
  - S_PRESS_CHK, key_sync=0, cnt=CNT_MAX-1: go to S_PRESSED, key_filter<=0, key_press<=1.
  - S_PRESS_CHK, key_sync=0, otherwise: cnt<=cnt+1.
  - S_PRESSED: key_sync=1 -> S_RELEASE_CHK, cnt<=0.
  - S_RELEASE_CHK: mirror of S_PRESS_CHK with polarity inverted. Bounce returns to S_PRESSED. Completion goes to S_RELEASED with key_filter<=1, key_release<=1.
- Strobes: key_press and key_release are high for exactly one cycle and default to 0 every other cycle; they are never high simultaneously.
- Latency: key_in changes just after edge 0.
  - key_sync changes at edge 2; FSM enters the CHK state at edge 3.
  - key_filter and the strobe update at edge CNT_MAX+3.
- Counter: cnt is only non-zero in CHK states. It never exceeds CNT_MAX-1 and never wraps. Any bounce sample restarts the count from 0.
- Rejected pulses: a low or high pulse shorter than CNT_MAX synchronised cycles produces no output change and no strobe.
- Held key: no auto-repeat; holding the key indefinitely yields exactly one key_press.
- Reset mid-operation: all outputs and state return to reset values immediately (asynchronous), including mid-count. If key_in is low when reset releases, it is filtered as a fresh press: key_press fires at edge CNT_MAX+3 after the first edge following deassertion.
- key_filter changes only on accepted transitions and is glitch-free, being registered.

Test Plan:
All scenarios use CNT_MAX=10.
1. Clean press: key_in 1->0 after edge 0, held 40 cycles -> key_filter falls at edge 13; key_press=1 for that single cycle only; key_release stays 0.
2. Glitch rejection: key_in low for 9 cycles then high, from idle -> key_filter stays 1, no strobes, FSM back in S_RELEASED by edge 13.
3. Bouncy press: key_in low 4, high 2, low 6, high 1, then low steady -> exactly one key_press, occurring 13 edges after the final 1->0 transition.
4. Release: from pressed, key_in 0->1 held -> key_filter rises at edge 13 after the change; key_release one cycle; a 9-cycle release glitch is rejected.
5. Reset mid-filter: assert sys_rst at cycle 7 of S_PRESS_CHK, then deassert with key_in still low -> outputs at reset values during reset; key_press at edge 13 after deassertion.
6. Idle and repeated use: key_in high for 1000 cycles -> no strobes. Then 3 clean press/release cycles of 30 cycles each -> exactly 3 key_press and 3 key_release strobes, alternating.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key debounce signal bundle: raw key input toward the filter, clean level and strobes back.
// The master side owns the raw key; the slave side is the debounce stage.
interface key_debounce_if;
  logic key_in;
  logic key_filter;
  logic key_press;
  logic key_release;

  modport master (
    output key_in,
    input  key_filter,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_filter,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Debounces an active-low push-button: 2-FF synchroniser, then a four-state filter that
// accepts a level change only after CNT_MAX consecutive stable samples.
module key_debounce #(
  parameter int CNT_MAX = 1_000_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  key_debounce_if.slave key_if
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_CHK,
    S_PRESSED,
    S_RELEASE_CHK
  } state_t;

  logic [1:0]       sync_reg;
  logic             key_sync;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             key_filter_reg;
  logic             key_press_reg;
  logic             key_release_reg;

  // Idle level of the key is high, so the chain resets to 1 to avoid a phantom press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], key_if.key_in};
    end
  end

  assign key_sync = sync_reg[1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg       <= S_RELEASED;
      cnt_reg         <= '0;
      key_filter_reg  <= 1'b1;
      key_press_reg   <= 1'b0;
      key_release_reg <= 1'b0;
    end else begin
      key_press_reg   <= 1'b0;
      key_release_reg <= 1'b0;
      case (state_reg)
        S_RELEASED: begin
          cnt_reg <= '0;
          if (!key_sync) begin
            state_reg <= S_PRESS_CHK;
          end
        end
        S_PRESS_CHK: begin
          if (key_sync) begin
            state_reg <= S_RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg      <= S_PRESSED;
            cnt_reg        <= '0;
            key_filter_reg <= 1'b0;
            key_press_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          cnt_reg <= '0;
          if (key_sync) begin
            state_reg <= S_RELEASE_CHK;
          end
        end
        S_RELEASE_CHK: begin
          if (!key_sync) begin
            state_reg <= S_PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg       <= S_RELEASED;
            cnt_reg         <= '0;
            key_filter_reg  <= 1'b1;
            key_release_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= S_RELEASED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_if.key_filter  = key_filter_reg;
  assign key_if.key_press   = key_press_reg;
  assign key_if.key_release = key_release_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=10: clean/bouncy presses, glitches, releases,
// reset mid-count and repeated use; a negedge monitor tallies strobes.
module tb_key_debounce;

  localparam int CNT_MAX = 10;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  int checks = 0;
  int errors = 0;

  int press_cnt   = 0;
  int release_cnt = 0;
  int alt_err     = 0;
  int both_err    = 0;
  int last_strobe = 0;   // 0 = last was release (idle), 1 = last was press

  int p0;
  int r0;

  key_debounce_if kif ();

  key_debounce #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_if  (kif.slave)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (kif.key_press && kif.key_release) both_err++;
      if (kif.key_press) begin
        press_cnt++;
        if (last_strobe == 1) alt_err++;
        last_strobe = 1;
      end
      if (kif.key_release) begin
        release_cnt++;
        if (last_strobe == 0) alt_err++;
        last_strobe = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    if (obs === exp) $display("check %s ok value=%0h", tag, obs);
  endtask

  task automatic check_outs(input string tag, input logic f, input logic p, input logic r);
    check({tag, "_filter"},  {31'd0, kif.key_filter},  {31'd0, f});
    check({tag, "_press"},   {31'd0, kif.key_press},   {31'd0, p});
    check({tag, "_release"}, {31'd0, kif.key_release}, {31'd0, r});
  endtask

  initial begin
    kif.key_in = 1'b1;
    #2;
    sys_rst = 1'b1;
    tick(3);
    check_outs("reset", 1'b1, 1'b0, 1'b0);
    sys_rst = 1'b0;
    tick(5);
    check_outs("idle_after_reset", 1'b1, 1'b0, 1'b0);

    // Clean press, held 40 cycles
    p0 = press_cnt; r0 = release_cnt;
    kif.key_in = 1'b0;
    tick(12);
    check_outs("press_e12", 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("press_e13", 1'b0, 1'b1, 1'b0);
    tick(1);
    check_outs("press_e14", 1'b0, 1'b0, 1'b0);
    tick(26);
    check("press_count_held", press_cnt - p0, 32'd1);
    check("press_no_release", release_cnt - r0, 32'd0);

    // 9-cycle release glitch while pressed
    r0 = release_cnt;
    kif.key_in = 1'b1;
    tick(9);
    kif.key_in = 1'b0;
    tick(20);
    check_outs("rel_glitch", 1'b0, 1'b0, 1'b0);
    check("rel_glitch_count", release_cnt - r0, 32'd0);

    // Clean release
    kif.key_in = 1'b1;
    tick(12);
    check_outs("release_e12", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("release_e13", 1'b1, 1'b0, 1'b1);
    tick(1);
    check_outs("release_e14", 1'b1, 1'b0, 1'b0);
    tick(10);

    // 9-cycle press glitch from idle
    p0 = press_cnt;
    kif.key_in = 1'b0;
    tick(9);
    kif.key_in = 1'b1;
    tick(6);
    check_outs("press_glitch", 1'b1, 1'b0, 1'b0);
    check("press_glitch_count", press_cnt - p0, 32'd0);
    tick(5);

    // Bouncy press: low 4, high 2, low 6, high 1, then low steady
    p0 = press_cnt;
    kif.key_in = 1'b0; tick(4);
    kif.key_in = 1'b1; tick(2);
    kif.key_in = 1'b0; tick(6);
    kif.key_in = 1'b1; tick(1);
    kif.key_in = 1'b0;
    tick(12);
    check_outs("bounce_e12", 1'b1, 1'b0, 1'b0);
    check("bounce_early_count", press_cnt - p0, 32'd0);
    tick(1);
    check_outs("bounce_e13", 1'b0, 1'b1, 1'b0);
    tick(30);
    check("bounce_count", press_cnt - p0, 32'd1);
    kif.key_in = 1'b1;
    tick(20);
    check_outs("bounce_released", 1'b1, 1'b0, 1'b0);

    // Reset during the seventh cycle of the press check, key held low through it
    kif.key_in = 1'b0;
    tick(9);
    sys_rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b1, 1'b0, 1'b0);
    tick(3);
    check_outs("rst_held", 1'b1, 1'b0, 1'b0);
    sys_rst = 1'b0;
    tick(12);
    check_outs("rst_rel_e12", 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("rst_rel_e13", 1'b0, 1'b1, 1'b0);
    tick(1);
    check_outs("rst_rel_e14", 1'b0, 1'b0, 1'b0);
    kif.key_in = 1'b1;
    tick(20);
    check_outs("rst_released", 1'b1, 1'b0, 1'b0);

    // Long idle then three clean press/release cycles
    p0 = press_cnt; r0 = release_cnt;
    tick(1000);
    check("idle_press", press_cnt - p0, 32'd0);
    check("idle_release", release_cnt - r0, 32'd0);
    check_outs("idle_1000", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      kif.key_in = 1'b0; tick(30);
      kif.key_in = 1'b1; tick(30);
    end
    check("repeat_press", press_cnt - p0, 32'd3);
    check("repeat_release", release_cnt - r0, 32'd3);
    check("alternation", alt_err, 32'd0);
    check("no_simultaneous", both_err, 32'd0);
    check_outs("repeat_end", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
